// File: rtl/alu_instr_encoder.sv
// alu_instr_encoder
//   Turns an ALU operation code plus register/immediate fields into the
//   matching RV32I OP (R-type) or OP-IMM (I-type) instruction word. Encoded
//   words are queued in a DEPTH-entry FIFO. Illegal requests are consumed,
//   dropped and counted.
//
//   ALU operation codes are {funct7[5], funct3}, as produced by the decode path:
//     ADD 0000  SUB 1000  SLL 0001  SLT 0010  SLTU 0011
//     XOR 0100  SRL 0101  SRA 1101  OR  0110  AND  0111
//   All other codes are illegal.
//
// Ports
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   in_valid/ready  request handshake; in_ready depends only on occupancy
//   in_aluctl       ALU operation code
//   in_use_imm      1 = OP-IMM, 0 = OP
//   in_rd/rs1/rs2   register fields (rs2 unused for OP-IMM)
//   in_imm          12-bit immediate (unused for OP)
//   out_valid/ready output handshake at the FIFO head
//   out_instr       instruction word at the head; holds last value when empty
//   err_pulse       one cycle after an accepted illegal request
//   err_count       saturating count of illegal requests
//   level           current FIFO occupancy
module alu_instr_encoder #(
   parameter int DEPTH = 4,
   parameter int ERRW  = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [3:0]                 in_aluctl,
   input  logic                       in_use_imm,
   input  logic [4:0]                 in_rd,
   input  logic [4:0]                 in_rs1,
   input  logic [4:0]                 in_rs2,
   input  logic [11:0]                in_imm,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [31:0]                out_instr,
   output logic                       err_pulse,
   output logic [ERRW-1:0]            err_count,
   output logic [$clog2(DEPTH):0]     level
);

   localparam int PW = $clog2(DEPTH);
   localparam int LW = PW + 1;
   localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b1000;
   localparam logic [3:0] ALU_SLL  = 4'b0001;
   localparam logic [3:0] ALU_SLT  = 4'b0010;
   localparam logic [3:0] ALU_SLTU = 4'b0011;
   localparam logic [3:0] ALU_XOR  = 4'b0100;
   localparam logic [3:0] ALU_SRL  = 4'b0101;
   localparam logic [3:0] ALU_SRA  = 4'b1101;
   localparam logic [3:0] ALU_OR   = 4'b0110;
   localparam logic [3:0] ALU_AND  = 4'b0111;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] F7_ALT     = 7'b0100000;

   function automatic logic [2:0] alu_funct3(input logic [3:0] ctl);
      logic [2:0] f3;
      f3 = 3'b000;
      case (ctl)
         ALU_ADD, ALU_SUB: f3 = 3'b000;
         ALU_SLL:          f3 = 3'b001;
         ALU_SLT:          f3 = 3'b010;
         ALU_SLTU:         f3 = 3'b011;
         ALU_XOR:          f3 = 3'b100;
         ALU_SRL, ALU_SRA: f3 = 3'b101;
         ALU_OR:           f3 = 3'b110;
         ALU_AND:          f3 = 3'b111;
         default:          f3 = 3'b000;
      endcase
      return f3;
   endfunction

   function automatic logic is_known(input logic [3:0] ctl);
      logic k;
      k = 1'b0;
      case (ctl)
         ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
         ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND: k = 1'b1;
         default: k = 1'b0;
      endcase
      return k;
   endfunction

   function automatic logic is_shift(input logic [3:0] ctl);
      return (ctl == ALU_SLL) || (ctl == ALU_SRL) || (ctl == ALU_SRA);
   endfunction

   function automatic logic is_legal(input logic [3:0] ctl, input logic use_imm,
                                     input logic [11:0] imm);
      logic ok;
      ok = is_known(ctl);
      // There is no SUBI; shift amounts above 31 do not exist on RV32.
      if (use_imm && (ctl == ALU_SUB))
         ok = 1'b0;
      if (use_imm && is_shift(ctl) && (imm[11:5] != 7'd0))
         ok = 1'b0;
      return ok;
   endfunction

   function automatic logic [31:0] encode(input logic [3:0] ctl, input logic use_imm,
                                          input logic [4:0] rd, input logic [4:0] rs1,
                                          input logic [4:0] rs2, input logic [11:0] imm);
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [31:0] word;
      f3 = alu_funct3(ctl);
      f7 = ((ctl == ALU_SUB) || (ctl == ALU_SRA)) ? F7_ALT : 7'd0;
      if (!use_imm)
         word = {f7, rs2, rs1, f3, rd, OPC_OP};
      else if (is_shift(ctl))
         word = {f7, imm[4:0], rs1, f3, rd, OPC_OP_IMM};
      else
         word = {imm, rs1, f3, rd, OPC_OP_IMM};
      return word;
   endfunction

   function automatic logic [ERRW-1:0] sat_inc(input logic [ERRW-1:0] v);
      return (v == {ERRW{1'b1}}) ? v : v + 1'b1;
   endfunction

   logic [31:0]    r_mem [DEPTH];
   logic [PW-1:0]  r_wr_ptr;
   logic [PW-1:0]  r_rd_ptr;
   logic [LW-1:0]  r_level;
   logic [31:0]    r_last;
   logic           r_err_pulse;
   logic [ERRW-1:0] r_err_count;

   logic           w_accept;
   logic           w_legal;
   logic           w_push;
   logic           w_pop;
   logic [31:0]    w_word;

   assign in_ready  = (r_level != FULL_LVL);
   assign out_valid = (r_level != '0);
   // When empty, show the most recently popped word (0 after reset).
   assign out_instr = out_valid ? r_mem[r_rd_ptr] : r_last;
   assign err_pulse = r_err_pulse;
   assign err_count = r_err_count;
   assign level     = r_level;

   assign w_accept = in_valid & in_ready;
   assign w_legal  = is_legal(in_aluctl, in_use_imm, in_imm);
   assign w_push   = w_accept & w_legal;
   assign w_pop    = out_valid & out_ready;
   assign w_word   = encode(in_aluctl, in_use_imm, in_rd, in_rs1, in_rs2, in_imm);

   // Storage is only read where occupancy marks it valid, so it needs no reset.
   always_ff @(posedge clk) begin
      if (w_push)
         r_mem[r_wr_ptr] <= w_word;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_level     <= '0;
         r_last      <= '0;
         r_err_pulse <= 1'b0;
         r_err_count <= '0;
      end else begin
         if (w_push)
            r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
            r_last   <= r_mem[r_rd_ptr];
         end
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + LW'(1);
            2'b01:   r_level <= r_level - LW'(1);
            default: r_level <= r_level;
         endcase
         r_err_pulse <= w_accept & ~w_legal;
         if (w_accept && !w_legal)
            r_err_count <= sat_inc(r_err_count);
      end
   end

endmodule

// File: tb/tb_alu_instr_encoder.sv
module tb_alu_instr_encoder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  in_aluctl;
   logic        in_use_imm;
   logic [4:0]  in_rd;
   logic [4:0]  in_rs1;
   logic [4:0]  in_rs2;
   logic [11:0] in_imm;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic        err_pulse;
   logic [7:0]  err_count;
   logic [2:0]  level;

   int n_cmp  = 0;
   int n_fail = 0;

   alu_instr_encoder #(.DEPTH(4), .ERRW(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_aluctl  (in_aluctl),
      .in_use_imm (in_use_imm),
      .in_rd      (in_rd),
      .in_rs1     (in_rs1),
      .in_rs2     (in_rs2),
      .in_imm     (in_imm),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_instr  (out_instr),
      .err_pulse  (err_pulse),
      .err_count  (err_count),
      .level      (level)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout, expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] ctl, input logic use_imm, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [11:0] imm);
      in_valid   = 1'b1;
      in_aluctl  = ctl;
      in_use_imm = use_imm;
      in_rd      = rd;
      in_rs1     = rs1;
      in_rs2     = rs2;
      in_imm     = imm;
   endtask

   task automatic idle;
      in_valid = 1'b0;
   endtask

   // Push one request into an empty FIFO, check the head, then pop it.
   task automatic send_one(input string tag, input logic [3:0] ctl, input logic use_imm,
                           input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [11:0] imm, input logic [31:0] exp);
      drive(ctl, use_imm, rd, rs1, rs2, imm);
      tick;
      idle;
      chk({tag, "_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_instr"}, out_instr, exp);
      out_ready = 1'b1;
      tick;
      out_ready = 1'b0;
      chk({tag, "_level"}, 32'(level), 32'd0);
   endtask

   initial begin
      rst_n = 1'b0;
      in_valid = 1'b0; in_aluctl = '0; in_use_imm = 1'b0;
      in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
      out_ready = 1'b0;
      tick; tick;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_level",     32'(level),     32'd0);
      chk("rst_out_instr", out_instr,      32'd0);
      chk("rst_err_pulse", 32'(err_pulse), 32'd0);
      chk("rst_err_count", 32'(err_count), 32'd0);
      chk("rst_in_ready",  32'(in_ready),  32'd1);
      rst_n = 1'b1;
      tick;

      // Basic encodings
      send_one("add_r",  4'b0000, 1'b0, 5'd1, 5'd2, 5'd3, 12'h000, 32'h003100B3);
      chk("hold_after_pop", out_instr, 32'h003100B3);
      send_one("sub_r",  4'b1000, 1'b0, 5'd5, 5'd6, 5'd7, 12'hABC, 32'h407302B3);
      send_one("srai",   4'b1101, 1'b1, 5'd1, 5'd1, 5'd9, 12'h003, 32'h4030D093);
      send_one("addi",   4'b0000, 1'b1, 5'd1, 5'd0, 5'd31, 12'hFFF, 32'hFFF00093);
      send_one("sltiu",  4'b0011, 1'b1, 5'd2, 5'd3, 5'd0, 12'h7FF, 32'h7FF1B113);
      send_one("srli",   4'b0101, 1'b1, 5'd4, 5'd5, 5'd0, 12'h01F, 32'h01F2D213);
      send_one("or_r",   4'b0110, 1'b0, 5'd3, 5'd4, 5'd5, 12'h000, 32'h005261B3);

      // Inputs ignored while in_valid is low
      drive(4'b0000, 1'b0, 5'd9, 5'd9, 5'd9, 12'h0);
      in_valid = 1'b0;
      tick;
      chk("novalid_level", 32'(level), 32'd0);

      // Illegal requests
      drive(4'b1000, 1'b1, 5'd1, 5'd1, 5'd0, 12'h001);
      tick;
      chk("subi_pulse", 32'(err_pulse), 32'd1);
      chk("subi_count", 32'(err_count), 32'd1);
      drive(4'b0001, 1'b1, 5'd1, 5'd1, 5'd0, 12'h020);
      tick;
      chk("slli_pulse", 32'(err_pulse), 32'd1);
      chk("slli_count", 32'(err_count), 32'd2);
      chk("slli_level", 32'(level),     32'd0);
      chk("slli_valid", 32'(out_valid), 32'd0);
      drive(4'b1111, 1'b0, 5'd1, 5'd1, 5'd1, 12'h000);
      tick;
      idle;
      chk("badctl_count", 32'(err_count), 32'd3);
      tick;
      chk("pulse_clear", 32'(err_pulse), 32'd0);
      chk("err_hold",    32'(err_count), 32'd3);

      // Fill to full with out_ready low
      for (int k = 0; k < 4; k++) begin
         chk("fill_ready", 32'(in_ready), 32'd1);
         drive(4'b0000, 1'b1, 5'(10 + k), 5'd0, 5'd0, 12'(k + 1));
         tick;
      end
      chk("full_level", 32'(level),    32'd4);
      chk("full_ready", 32'(in_ready), 32'd0);
      drive(4'b0000, 1'b1, 5'd14, 5'd0, 5'd0, 12'd5);
      tick;
      chk("held_level", 32'(level),     32'd4);
      chk("held_head",  out_instr,      32'h00100513);
      chk("held_head2", out_instr,      32'h00100513);
      // Full + valid + out_ready: pop only, push waits
      out_ready = 1'b1;
      tick;
      chk("fullpop_level", 32'(level),    32'd3);
      chk("fullpop_ready", 32'(in_ready), 32'd1);
      chk("fullpop_head",  out_instr,     32'h00200593);
      // Held request now accepted while popping: level constant
      tick;
      idle;
      chk("pushpop_level", 32'(level), 32'd3);
      chk("pushpop_head",  out_instr,  32'h00300613);
      tick;
      chk("drain_head4", out_instr, 32'h00400693);
      tick;
      chk("drain_head5", out_instr,  32'h00500713);
      chk("drain_lvl1",  32'(level), 32'd1);
      tick;
      chk("drain_empty", 32'(out_valid), 32'd0);
      chk("drain_hold",  out_instr,      32'h00500713);
      out_ready = 1'b0;

      // Half-full simultaneous push and pop
      drive(4'b0100, 1'b0, 5'd1, 5'd2, 5'd3, 12'h0);
      tick; tick;
      chk("half_level", 32'(level), 32'd2);
      out_ready = 1'b1;
      tick;
      chk("half_pp_level", 32'(level), 32'd2);
      idle;
      out_ready = 1'b0;
      chk("xor_head", out_instr, 32'h003140B3);

      // Asynchronous reset mid-stream with 3 buffered
      drive(4'b0111, 1'b0, 5'd1, 5'd2, 5'd3, 12'h0);
      tick;
      idle;
      chk("pre_rst_level", 32'(level), 32'd3);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_valid", 32'(out_valid), 32'd0);
      chk("arst_level", 32'(level),     32'd0);
      chk("arst_err",   32'(err_count), 32'd0);
      chk("arst_instr", out_instr,      32'd0);
      @(posedge clk);
      #3;
      rst_n = 1'b1;
      tick;
      send_one("post_rst", 4'b0111, 1'b0, 5'd1, 5'd2, 5'd3, 12'h0, 32'h003170B3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
